icache_direct_mapped: RTL

Direct-mapped, read-only instruction cache between the Riscv141 fetch port (`icache_addr`, `icache_re`, `icache_dout`, `stall`) and the main-memory line interface. It serves hits with one-cycle registered latency. On a miss it asserts `stall`, fetches one 128-bit line through a valid/ready request and valid response, installs the line, and delivers the requested word. It is the block directly upstream of the CPU fetch stage.

---
 rtl/riscv141_pkg.sv | 29 ++
 rtl/icache_direct_mapped_if.sv | 35 +++
 rtl/icache_array.sv | 70 +++++++
 rtl/icache_direct_mapped.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/riscv141_pkg.sv
// Shared definitions for the Riscv141 instruction cache.
// Contents: line geometry constants, the refill FSM state type, and helper
// functions that derive the index and tag field widths from the cache shape.
package riscv141_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_BITS  = 128;
  // Byte offset within a line: 2 bits of word select + 2 bits of byte select.
  localparam int unsigned OFFSET_W   = 4;

  // A cache line viewed as words; word w sits at bits [32w+31:32w].
  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  typedef enum logic [1:0] {
    StLookup,
    StReq,
    StWait,
    StDeliver
  } icache_state_t;

  function automatic int unsigned idx_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned lines);
    return addr_w - OFFSET_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Main-memory line interface between the instruction cache and memory.
// Signals:
//   mem_req_valid  cache -> mem  line-fetch request valid
//   mem_req_ready  mem -> cache  request accepted
//   mem_req_addr   cache -> mem  line-aligned byte address
//   mem_resp_valid mem -> cache  line data valid (one cycle per request)
//   mem_resp_data  mem -> cache  128-bit line
// Modports: master (cache side), slave (memory side).
interface icache_direct_mapped_if #(
  parameter int unsigned ADDR_W = 32
);

  logic                               mem_req_valid;
  logic                               mem_req_ready;
  logic [ADDR_W-1:0]                  mem_req_addr;
  logic                               mem_resp_valid;
  logic [riscv141_pkg::LINE_BITS-1:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data store for the direct-mapped instruction cache.
// Ports:
//   clk, reset         clock, asynchronous active-low reset (clears valid bits)
//   rd_en, rd_idx      registered read of one set; results appear next cycle
//   flush              clear every valid bit in one cycle
//   wr_en, wr_idx,     line install: writes tag and data, sets valid
//   wr_tag, wr_line
//   rd_valid, rd_tag,  registered read results
//   rd_line
// Tag and data storage are deliberately not reset.
module icache_array
  import riscv141_pkg::*;
#(
  parameter int unsigned  LINES = 64,
  parameter int unsigned  TAG_W = 22,
  localparam int unsigned IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  line_t            wr_line,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output line_t            rd_line
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  line_t            data_mem [LINES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  // A read in the same cycle as a flush must see the line as invalid, so the
  // flush takes effect before the lookup.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= !flush && valid_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_line <= data_mem[rd_idx];
    end
  end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache for the Riscv141 fetch stage.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   icache_addr   fetch byte address (bits [1:0] ignored)
//   icache_re     fetch request, accepted when stall=0
//   icache_dout   instruction word for the last accepted request
//   stall         high while the accepted request is not yet served
//   flush         invalidate all lines, accepted when stall=0
//   mem_bus       line-fetch request / response interface (master side)
//   miss_count    saturating miss counter
// Hits return one cycle after acceptance; misses fetch a full line, install
// it and deliver the requested word.
module icache_direct_mapped
  import riscv141_pkg::*;
#(
  parameter int unsigned LINES  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      icache_addr,
  input  logic                   icache_re,
  output logic [31:0]            icache_dout,
  output logic                   stall,
  input  logic                   flush,
  icache_direct_mapped_if.master mem_bus,
  output logic [31:0]            miss_count
);

  localparam int unsigned IDX_W = idx_width(LINES);
  localparam int unsigned TAG_W = tag_width(ADDR_W, LINES);

  icache_state_t     state_q, state_d;
  logic [ADDR_W-1:0] req_q;
  logic              pend_q;   // a request was accepted at the last edge
  logic [31:0]       dout_q;
  logic [31:0]       miss_q;

  logic              accept;
  logic              flush_eff;
  logic              hit;
  logic              lookup_hit;
  logic              miss;
  logic              install;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  line_t             rd_line;
  line_t             resp_line;

  logic [1:0]        req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              unused_byte_off;

  assign req_word        = req_q[3:2];
  assign req_idx         = req_q[OFFSET_W +: IDX_W];
  assign req_tag         = req_q[ADDR_W-1 -: TAG_W];
  assign unused_byte_off = ^req_q[1:0];
  assign resp_line       = mem_bus.mem_resp_data;

  assign accept    = !stall && icache_re;
  assign flush_eff = !stall && flush;
  assign hit       = rd_valid && (rd_tag == req_tag);

  icache_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (accept),
    .rd_idx   (icache_addr[OFFSET_W +: IDX_W]),
    .flush    (flush_eff),
    .wr_en    (install),
    .wr_idx   (req_idx),
    .wr_tag   (req_tag),
    .wr_line  (resp_line),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line)
  );

  // Next state and outputs. Every output depends only on registered state,
  // so stall and the memory request are stable across the clock edge.
  always_comb begin
    state_d               = state_q;
    stall                 = 1'b0;
    miss                  = 1'b0;
    install               = 1'b0;
    lookup_hit            = 1'b0;
    mem_bus.mem_req_valid = 1'b0;
    mem_bus.mem_req_addr  = '0;
    unique case (state_q)
      StLookup: begin
        if (pend_q) begin
          if (hit) begin
            lookup_hit = 1'b1;
          end else begin
            stall   = 1'b1;
            miss    = 1'b1;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        stall                 = 1'b1;
        mem_bus.mem_req_valid = 1'b1;
        mem_bus.mem_req_addr  = {req_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        if (mem_bus.mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        stall = 1'b1;
        if (mem_bus.mem_resp_valid) begin
          install = 1'b1;
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        state_d = StLookup;
      end
      default: begin
        state_d = StLookup;
      end
    endcase
  end

  // Hit data comes straight from the array's read register; otherwise the
  // last delivered word is held.
  assign icache_dout = lookup_hit ? rd_line[req_word] : dout_q;
  assign miss_count  = miss_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StLookup;
      req_q   <= '0;
      pend_q  <= 1'b0;
      dout_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= accept;
      if (accept) begin
        req_q <= icache_addr;
      end
      if (install) begin
        dout_q <= resp_line[req_word];
      end else if (lookup_hit) begin
        dout_q <= rd_line[req_word];
      end
      if (miss && (miss_q != 32'hFFFF_FFFF)) begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

endmodule
